uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receives asynchronous UART frames on a single serial input.
- Frame format: 8E1 (1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit).
- Default rate is 115200 baud from a 100 MHz clock.
- Delivers each byte with a one-cycle `ready` strobe and an `error` flag; sits between the board RX pin and byte-level consumer logic.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200).
- SYNC_STAGES, 2, flip-flop stages in the rx input synchronizer (minimum 2).

Ports:
- rst  input  1  synchronous reset, active-high (first positional port)
- clk  input  1  single system clock, rising edge (second positional port)
- rx  input  1  asynchronous serial line; idles high
- ready  output  1  one-cycle strobe: a frame has completed and `val` is updated
- error  output  1  one-cycle strobe, coincident with `ready`: parity mismatch or bad stop bit
- val  output  8  last received data byte; holds between frames

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - ready=0, error=0, val=8'h00.
  - State=IDLE, counters=0.
  - Synchronizer flops are set to 1, so no false start bit is seen after reset.
- Input synchronization: rx passes through SYNC_STAGES flops; all logic uses the synchronized value rx_s.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Waits for rx_s==0.
  - On detection, clear the cycle counter and go to START.
- START:
  - Count CLKS_PER_BIT/2 cycles (434), then sample rx_s at mid-bit.
  - If rx_s==1, treat as a glitch: return to IDLE with no ready and no error.
  - Otherwise clear the counter and the bit index, and go to DATA.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register bit[idx], LSB first (idx 0..7).
  - After idx 7 is sampled, go to PARITY.
- PARITY:
  - After CLKS_PER_BIT cycles, sample the parity bit.
  - parity_ok = (parity bit == XOR of the 8 data bits), i.e. even parity over data plus parity.
  - Go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample the stop bit.
  - On the following clock edge:
    - val <= shift register;
    - ready <= 1 for exactly one cycle;
    - error <= (!parity_ok || stop bit==0) for that same cycle;
    - state <= IDLE.
  - val is updated even when error=1.
- Return to IDLE happens at mid-stop-bit. A new start edge arriving in the remaining half stop bit, or immediately after it, must be accepted, so back-to-back frames are supported.
- If the stop bit is 0 (framing error / break), go to IDLE anyway. Because rx_s is low, IDLE immediately begins a new START check. This is the required behaviour.
- Latency: from rx falling edge to ready ≈ SYNC_STAGES + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles (≈9117 cycles, ≈91.2 µs at defaults). Tolerance ±3 cycles.
- ready and error are never asserted outside a completed frame. error is 0 whenever ready is 0.
- rst asserted mid-frame aborts reception: outputs return to reset values on the next edge, and the partial frame is discarded.
- Counter widths: sized by $clog2(CLKS_PER_BIT). No dependence on any other clock frequency.

Test Plan:
- Idle line high for 20 µs after reset → ready, error and val remain 0.
- Three frames at 8680 ns/bit: start 0, data 1,0,1,0,1,0,0,1 (LSB first), parity 0, stop 1, with 20 µs idle between frames → three ready pulses, each with val=8'h95 and error=0.
- Same frame with parity bit 1 → ready pulse, val=8'h95, error=1.
- Same frame with stop bit 0 → ready pulse with error=1. After rx returns high, a following valid 0x95 frame gives error=0.
- 2 µs low glitch on idle line → no ready pulse; the next valid frame is received correctly.
- rst asserted for 100 ns in the middle of the data bits → outputs reset, no ready pulse for that frame; the next full frame yields val=8'h95, error=0.
- Back-to-back frames 0x00 (parity 0) then 0xFF (parity 0), with a stop bit of exactly one bit period → two ready pulses, val=8'h00 then 8'hFF, error=0 both times.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8E1 asynchronous serial receiver.
// Mid-bit sampling with a per-bit cycle counter.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       rx,
  output logic       ready,
  output logic       error,
  output logic [7:0] val
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          par_ok;
  logic          par_ok_n;
  logic          ready_n;
  logic          error_n;
  logic [7:0]    val_n;
  logic          tick_full;
  logic          tick_half;

  assign rx_s      = sync[SYNC_STAGES-1];
  assign tick_full = (cnt == LAST);
  assign tick_half = (cnt == MID);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '1;
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      par_ok <= 1'b0;
      ready  <= 1'b0;
      error  <= 1'b0;
      val    <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], rx};
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      par_ok <= par_ok_n;
      ready  <= ready_n;
      error  <= error_n;
      val    <= val_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    shreg_n  = shreg;
    par_ok_n = par_ok;
    ready_n  = 1'b0;
    error_n  = 1'b0;
    val_n    = val;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (tick_half) begin
          cnt_n   = '0;
          idx_n   = '0;
          // a high line at mid-start is a glitch
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_full) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (tick_full) begin
          cnt_n    = '0;
          par_ok_n = (rx_s == ^shreg);
          state_n  = STOP;
        end
      end
      STOP: begin
        if (tick_full) begin
          // leave at mid-stop so back-to-back starts are caught
          cnt_n   = '0;
          state_n = IDLE;
          ready_n = 1'b1;
          error_n = !par_ok || !rx_s;
          val_n   = shreg;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed 8E1 frames
// against a queue-based frame model.
module tb_uart_rx;

  localparam int CPB = 64;
  localparam int SYN = 2;
  localparam int LAT = SYN + CPB / 2 + 10 * CPB + 1;

  logic       rst;
  logic       clk;
  logic       rx;
  logic       ready;
  logic       error;
  logic [7:0] val;

  typedef struct {
    logic [7:0] d;
    logic       err;
    int         fall;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYN)
  ) dut (
    .rst  (rst),
    .clk  (clk),
    .rx   (rx),
    .ready(ready),
    .error(error),
    .val  (val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h",
               tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       pflip,
    input logic       stop,
    input int         idle
  );
    exp_t e;
    e.d    = d;
    e.err  = pflip || !stop;
    e.fall = cyc;
    expq.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ pflip);
    send_bit(stop);
    repeat (idle) send_bit(1'b1);
  endtask

  always @(negedge clk) begin
    int   lat;
    exp_t e;
    if (!rst) begin
      if (error && !ready)
        check("err_wo_ready", error, 0);
      if (ready) begin
        if (expq.size() == 0) begin
          check("spurious_ready", ready, 0);
        end else begin
          e   = expq.pop_front();
          lat = cyc - e.fall;
          check("val", val, e.d);
          check("error", error, e.err);
          if (lat >= LAT - 3 && lat <= LAT + 3)
            lat = LAT;
          check("latency", lat, LAT);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", ready, 0);
    check("rst_error", error, 0);
    check("rst_val", val, 0);
    repeat (2 * CPB) @(negedge clk);
    check("idle_val", val, 0);

    repeat (3) send_frame(8'h95, 1'b0, 1'b1, 2);
    check("val_hold", val, 8'h95);
    send_frame(8'h95, 1'b1, 1'b1, 2);
    send_frame(8'h95, 1'b0, 1'b0, 2);
    send_frame(8'h95, 1'b0, 1'b1, 2);

    rx = 1'b0;
    repeat (15) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h95, 1'b0, 1'b1, 2);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    check("abort_ready", ready, 0);
    check("abort_error", error, 0);
    check("abort_val", val, 0);
    repeat (12 * CPB) @(negedge clk);
    send_frame(8'h95, 1'b0, 1'b1, 2);

    send_frame(8'h00, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 2);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic       pf;
      logic       sb;
      int         idl;
      d   = 8'($urandom);
      pf  = ($urandom_range(0, 3) == 0);
      sb  = ($urandom_range(0, 3) != 0);
      idl = sb ? $urandom_range(0, 2)
               : $urandom_range(1, 2);
      send_frame(d, pf, sb, idl);
    end

    repeat (3 * CPB) @(negedge clk);
    check("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
